// File: rtl/iis_pkg.sv
// rtl/iis_pkg.sv - shared state type and constants for the I2S transmitter
package iis_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } iis_tx_state_e;

  localparam logic IIS_CH_LEFT     = 1'b0;
  localparam logic IIS_CH_RIGHT    = 1'b1;
  localparam int   IIS_MIN_CLK_DIV = 2;

endpackage

// File: rtl/iis_bclk_gen.sv
// rtl/iis_bclk_gen.sv - BCLK divider with rise/fall strobes, cleared while not running
module iis_bclk_gen
  import iis_pkg::*;
#(
  parameter int clk_div = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic bclk_o,
  output logic rise_o,
  output logic fall_o
);

  // Values below the minimum cannot guarantee capture before the next load.
  localparam int DIV = (clk_div < IIS_MIN_CLK_DIV) ? IIS_MIN_CLK_DIV : clk_div;
  localparam int CW  = $clog2(DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bclk_q, bclk_d;
  logic          tc;

  assign tc = run_i && (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d  = cnt_q;
    bclk_d = bclk_q;
    if (!run_i) begin
      cnt_d  = '0;
      bclk_d = 1'b0;
    end else if (tc) begin
      cnt_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk_o = bclk_q;
  assign rise_o = tc && !bclk_q;
  assign fall_o = tc && bclk_q;

endmodule

// File: rtl/iis_tx.sv
// rtl/iis_tx.sv - I2S master transmitter fed from a FIFO read port
// IIS_TX_HOLD_LAST_EN: on underrun repeat the last word instead of sending silence.
module iis_tx
  import iis_pkg::*;
#(
  parameter int data_width = 16,
  parameter int clk_div    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic                  fifo_vaild,
  input  logic [data_width-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  iis_bclk,
  output logic                  iis_lrck,
  output logic                  iis_sdata,
  output logic                  underrun
);

  localparam int BW = $clog2(data_width);

  iis_tx_state_e         state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d, bit_nxt;
  logic [data_width-1:0] hold_q, hold_d, shift_q, shift_d;
  logic                  lrck_q, lrck_d, sdata_q, sdata_d;
  logic                  rd_en_q, rd_en_d, underrun_q, underrun_d;
  logic                  pend_q, pend_d;
  logic                  run, fall, fetch, unused_rise;

  assign run = (state_q == RUN) && en;

  iis_bclk_gen #(.clk_div(clk_div)) u_bclk_gen (
    .clk    (clk),
    .rst    (rst),
    .run_i  (run),
    .bclk_o (iis_bclk),
    .rise_o (unused_rise),
    .fall_o (fall)
  );

  assign bit_nxt = (bit_cnt_q == BW'(data_width - 1)) ? '0 : bit_cnt_q + BW'(1);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    hold_d     = hold_q;
    shift_d    = shift_q;
    lrck_d     = lrck_q;
    sdata_d    = sdata_q;
    pend_d     = pend_q;
    rd_en_d    = 1'b0;
    underrun_d = 1'b0;
    fetch      = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d   = RUN;
          bit_cnt_d = '0;
          lrck_d    = IIS_CH_LEFT;
          fetch     = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          hold_d    = '0;
          shift_d   = '0;
          lrck_d    = 1'b0;
          sdata_d   = 1'b0;
          pend_d    = 1'b0;
        end else begin
          if (pend_q && fifo_vaild) begin
            hold_d = fifo_dout;
            pend_d = 1'b0;
          end
          if (fall) begin
            bit_cnt_d = bit_nxt;
            if (bit_nxt == BW'(1)) begin
              shift_d = hold_q;
              sdata_d = hold_q[data_width-1];
            end else begin
              shift_d = shift_q << 1;
              sdata_d = shift_q[data_width-2];
            end
            // Slot boundary: LSB goes out one BCLK late, with the new word select.
            if (bit_nxt == '0) begin
              lrck_d = (lrck_q == IIS_CH_LEFT) ? IIS_CH_RIGHT : IIS_CH_LEFT;
              fetch  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (fetch) begin
      if (!fifo_empty) begin
        rd_en_d = 1'b1;
        pend_d  = 1'b1;
      end else begin
        underrun_d = 1'b1;
`ifdef IIS_TX_HOLD_LAST_EN
        hold_d = hold_q;
`else
        hold_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      hold_q     <= '0;
      shift_q    <= '0;
      lrck_q     <= 1'b0;
      sdata_q    <= 1'b0;
      pend_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_q     <= hold_d;
      shift_q    <= shift_d;
      lrck_q     <= lrck_d;
      sdata_q    <= sdata_d;
      pend_q     <= pend_d;
      rd_en_q    <= rd_en_d;
      underrun_q <= underrun_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign iis_lrck   = lrck_q;
  assign iis_sdata  = sdata_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_iis_tx.sv
// tb/tb_iis_tx.sv - randomized self-checking bench for iis_tx against a slot-level model
module tb_iis_tx;

  localparam int W   = 16;
  localparam int DIV = 2;
  localparam int P   = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         fifo_empty = 1'b1;
  logic         fifo_vaild = 1'b0;
  logic [W-1:0] fifo_dout  = '0;
  logic         fifo_rd_en, iis_bclk, iis_lrck, iis_sdata, underrun;

  iis_tx #(.data_width(W), .clk_div(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_vaild (fifo_vaild),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .iis_bclk   (iis_bclk),
    .iis_lrck   (iis_lrck),
    .iis_sdata  (iis_sdata),
    .underrun   (underrun)
  );

  always #(P/2) clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO read port: pop on rd_en, data valid one cycle later.
  logic [W-1:0] fq[$];
  logic         pop_pend = 1'b0;
  logic [W-1:0] pop_data = '0;

  always @(negedge clk) begin
    fifo_vaild = pop_pend;
    if (pop_pend) fifo_dout = pop_data;
    pop_pend = 1'b0;
    if (fifo_rd_en && fq.size() > 0) begin
      pop_data = fq.pop_front();
      pop_pend = 1'b1;
    end
    fifo_empty = (fq.size() == 0);
  end

  // Model: fall n carries bit W-1-j of slot word s, where n-1 = s*W + j;
  // lrck after fall n is (n / W) mod 2.
  logic [W-1:0] exp_words[$];
  logic         mon_on = 1'b0;
  int           fall_base = 0, rise_base = 0, rd_base = 0, ur_base = 0;
  int           fall_n = 0, rise_n = 0, rd_n = 0, ur_n = 0;
  time          t_rise1 = 0, t_rise2 = 0, t_fall1 = 0;
  logic         prev_bclk = 1'b0;

  always @(negedge clk) begin
    if (fifo_rd_en) rd_n++;
    if (underrun) ur_n++;
    if (mon_on) begin
      if (!prev_bclk && iis_bclk) begin
        rise_n++;
        if (rise_n - rise_base == 1) t_rise1 = $time;
        if (rise_n - rise_base == 2) t_rise2 = $time;
      end
      if (prev_bclk && !iis_bclk) begin
        int rel, s, j;
        fall_n++;
        rel = fall_n - fall_base;
        if (rel == 1) t_fall1 = $time;
        s = (rel - 1) / W;
        j = (rel - 1) % W;
        if (s < exp_words.size()) begin
          check("sdata", iis_sdata, exp_words[s][W-1-j]);
          check("lrck", iis_lrck, (rel / W) % 2);
        end
      end
    end
    prev_bclk = iis_bclk;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_bclk"}, iis_bclk, 0);
    check({tag, "_lrck"}, iis_lrck, 0);
    check({tag, "_sdata"}, iis_sdata, 0);
    check({tag, "_rd_en"}, fifo_rd_en, 0);
    check({tag, "_underrun"}, underrun, 0);
  endtask

  task automatic start_run(output time t_en);
    tick();
    fall_base = fall_n;
    rise_base = rise_n;
    rd_base   = rd_n;
    ur_base   = ur_n;
    mon_on    = 1'b1;
    en        = 1'b1;
    t_en      = $time;
  endtask

  task automatic wait_fall(input int n);
    int k = 0;
    while (fall_n - fall_base < n && k < 4000) begin
      tick();
      k++;
    end
    check("fall_reached", (fall_n - fall_base >= n), 1);
  endtask

  task automatic stop_run();
    mon_on = 1'b0;
    en     = 1'b0;
    repeat (2) tick();
    fq.delete();
    repeat (3) tick();
  endtask

  logic [W-1:0] fill;
  time          t_en;

  initial begin
    rst = 1'b0;
    en  = 1'b0;
`ifdef IIS_TX_HOLD_LAST_EN
    fill = 16'h1234;
`else
    fill = 16'h0000;
`endif
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b1;
    tick();

    // Two-word frame with divider timing.
    fq = '{16'hA5F0, 16'h0F0F};
    exp_words = '{16'hA5F0, 16'h0F0F};
    start_run(t_en);
    wait_fall(31);
    check("t1_pops", rd_n - rd_base, 2);
    check("t1_underruns", ur_n - ur_base, 0);
    check("t1_first_rise", (t_rise1 - (t_en - 1) - P) / P, DIV);
    check("t1_first_fall", (t_fall1 - (t_en - 1) - P) / P, 2 * DIV);
    check("t1_bclk_period", (t_rise2 - t_rise1) / P, 2 * DIV);
    stop_run();
    check_idle("t1_idle");

    // Right-channel fetch finds the FIFO empty.
    fq = '{16'h1234};
    exp_words = '{16'h1234, fill};
    start_run(t_en);
    wait_fall(31);
    check("t2_pops", rd_n - rd_base, 1);
    check("t2_underruns", ur_n - ur_base, 1);
    stop_run();

    // Enable dropped mid left slot.
    fq = '{16'hBEEF, 16'hCAFE, 16'h5A5A};
    exp_words = '{16'hBEEF};
    start_run(t_en);
    wait_fall(5);
    mon_on = 1'b0;
    en = 1'b0;
    tick();
    check_idle("t3_drop");
    // Enable pulse whose fetch data returns after falling back to IDLE.
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    check_idle("t3_pending");
    repeat (3) tick();
    exp_words = '{16'h5A5A};
    start_run(t_en);
    wait_fall(16);
    check("t3_pops", rd_n - rd_base, 1);
    stop_run();

    // Asynchronous reset mid-frame.
    fq = '{16'h8001, 16'h7FFE};
    exp_words = '{16'h8001, 16'h7FFE};
    start_run(t_en);
    wait_fall(20);
    mon_on = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_idle("t4_async");
    en = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    fq.delete();
    fq.push_back(16'hFFFF);
    repeat (10) tick();
    check_idle("t4_released");
    fq.delete();
    repeat (2) tick();

    // Eight frames back to back, random samples.
    exp_words.delete();
    fq.delete();
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] v;
      v = W'($urandom);
      fq.push_back(v);
      exp_words.push_back(v);
    end
    start_run(t_en);
    wait_fall(16 * W - 1);
    check("t5_pops", rd_n - rd_base, 16);
    check("t5_underruns", ur_n - ur_base, 0);
    stop_run();
    check_idle("t5_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
